// File: rtl/rll_pkg.sv
// rll_pkg: shared states and key-gate helpers for the keyed pipeline.
package rll_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, PAR, ARMED} state_t;
   function automatic int key_idx(input int i, input int kw);
      return i % kw;
   endfunction
   function automatic logic keygate(input logic d, input logic k, input logic p);
      return d ^ k ^ p;
   endfunction
endpackage

// File: rtl/rll_pipe_stage.sv
// rll_pipe_stage: one valid/ready register slice; ld comes from the downstream ready chain.
module rll_pipe_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic         in_vld,
   input  logic [W-1:0] in_data,
   output logic         out_vld,
   output logic [W-1:0] out_data
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (ld) begin
         out_vld <= in_vld;
         if (in_vld) out_data <= in_data;
      end
endmodule

// File: rtl/rll_keyed_pipe.sv
// rll_keyed_pipe: serial key loader with atomic commit feeding XOR/XNOR key gates on a pipelined stream.
// Define KEY_PARITY_EN to require an even-parity bit after the key (PAR state, key_err on mismatch).
module rll_keyed_pipe
   import rll_pkg::*;
#(
   parameter int               DATA_W      = 32,
   parameter int               KEY_W       = 32,
   parameter logic [KEY_W-1:0] KEY_POL     = '0,
   parameter int               PIPE_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_start,
   input  logic              key_sin,
   input  logic              key_sin_vld,
   output logic              key_busy,
   output logic              key_done,
   output logic              key_armed,
   output logic              key_err,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_vld,
   output logic              in_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_vld,
   input  logic              out_rdy
);
   localparam int CW = $clog2(KEY_W + 1);
   state_t           st, st_n;
   logic [KEY_W-1:0] sh, sh_n, sh_b, key, key_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             armed, armed_n, done, done_n, err, err_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st    <= IDLE;
         sh    <= '0;
         key   <= '0;
         cnt   <= '0;
         armed <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         st    <= st_n;
         sh    <= sh_n;
         key   <= key_n;
         cnt   <= cnt_n;
         armed <= armed_n;
         done  <= done_n;
         err   <= err_n;
      end
   // shadow is cleared on every start, so OR-ing the new bit in is a write
   always_comb begin
      st_n    = st;
      sh_n    = sh;
      key_n   = key;
      cnt_n   = cnt;
      armed_n = armed;
      done_n  = 1'b0;
      err_n   = 1'b0;
      sh_b    = sh | (KEY_W'(key_sin) << cnt);
      if (key_start) begin
         st_n  = LOAD;
         sh_n  = '0;
         cnt_n = '0;
      end else if (st == LOAD && key_sin_vld) begin
         sh_n  = sh_b;
         cnt_n = cnt + 1'b1;
         if (cnt == CW'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
            st_n = PAR;
`else
            st_n    = ARMED;
            key_n   = sh_b;
            armed_n = 1'b1;
            done_n  = 1'b1;
`endif
         end
      end
`ifdef KEY_PARITY_EN
      else if (st == PAR && key_sin_vld) begin
         sh_n  = '0;
         cnt_n = '0;
         if (^{sh, key_sin}) begin
            err_n = 1'b1;
            st_n  = armed ? ARMED : IDLE;
         end else begin
            key_n   = sh;
            armed_n = 1'b1;
            done_n  = 1'b1;
            st_n    = ARMED;
         end
      end
`endif
   end
   assign key_busy  = (st == LOAD) || (st == PAR);
   assign key_armed = armed;
   assign key_done  = done;
   assign key_err   = err;
   logic [DATA_W-1:0]      gated;
   logic [DATA_W-1:0]      d [PIPE_STAGES+1];
   logic [PIPE_STAGES:0]   v;
   logic [PIPE_STAGES-1:0] r;
   for (genvar i = 0; i < DATA_W; i++) begin : g_gate
      localparam int J = key_idx(i, KEY_W);
      assign gated[i] = keygate(in_data[i], key[J], KEY_POL[J]);
   end
   assign v[0] = in_vld & armed;
   assign d[0] = gated;
   // a stage can load iff some stage at or after it is empty, or the sink drains
   for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      assign r[s] = out_rdy | ~&v[PIPE_STAGES:s+1];
      rll_pipe_stage #(.W(DATA_W)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .ld      (r[s]),
         .in_vld  (v[s]),
         .in_data (d[s]),
         .out_vld (v[s+1]),
         .out_data(d[s+1])
      );
   end
   assign in_rdy   = armed & r[0];
   assign out_vld  = v[PIPE_STAGES];
   assign out_data = d[PIPE_STAGES];
endmodule

// File: tb/tb_rll_keyed_pipe.sv
// tb_rll_keyed_pipe: randomized scenarios checked against a word-level scoreboard and key-load model.
module tb_rll_keyed_pipe;
   localparam int               DW  = 32;
   localparam int               KW  = 32;
   localparam logic [KW-1:0]    POL = '0;
   localparam int               NS  = 2;
   logic          clk = 0, rst_n = 0;
   logic          key_start = 0, key_sin = 0, key_sin_vld = 0;
   logic          key_busy, key_done, key_armed, key_err;
   logic [DW-1:0] in_data = '0, out_data;
   logic          in_vld = 0, in_rdy, out_vld, out_rdy = 1;
   int            checks = 0, errors = 0;
   rll_keyed_pipe #(.DATA_W(DW), .KEY_W(KW), .KEY_POL(POL), .PIPE_STAGES(NS)) dut (
      .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_sin(key_sin), .key_sin_vld(key_sin_vld),
      .key_busy(key_busy), .key_done(key_done), .key_armed(key_armed), .key_err(key_err),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy)
   );
   always #5 clk = ~clk;
   // reference model: words in flight plus a bit-counting key loader
   logic [DW-1:0] q[$];
   logic [KW-1:0] mkey = '0, msh = '0;
   int            mcnt = 0;
   bit            mbusy = 0, marmed = 0, edone = 0, eerr = 0, pv = 0, pr = 0;
   logic [DW-1:0] pd = '0;
   function automatic logic [DW-1:0] mask(input logic [KW-1:0] k);
      for (int i = 0; i < DW; i++) mask[i] = k[i % KW] ^ POL[i % KW];
   endfunction
   task automatic commit();
      mkey = msh; marmed = 1; mbusy = 0; edone = 1;
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete(); mkey = '0; msh = '0; mcnt = 0; mbusy = 0; marmed = 0; edone = 0; eerr = 0; pv = 0;
         checks++;
         if ({out_vld, in_rdy, key_armed, key_busy, key_done, key_err} !== 6'b0 || out_data !== '0) begin
            errors++; $display("FAIL reset_outputs: vld=%b rdy=%b armed=%b busy=%b done=%b err=%b data=%h, want all 0", out_vld, in_rdy, key_armed, key_busy, key_done, key_err, out_data);
         end
      end else begin
         checks++;
         if ({key_busy, key_armed, key_done, key_err} !== {mbusy, marmed, edone, eerr}) begin
            errors++; $display("FAIL key_status: busy/armed/done/err=%b%b%b%b want %b%b%b%b", key_busy, key_armed, key_done, key_err, mbusy, marmed, edone, eerr);
         end
         checks++;
         if (in_rdy !== (marmed && (q.size() < NS || out_rdy))) begin
            errors++; $display("FAIL in_rdy: got %b want %b (inflight %0d out_rdy %b)", in_rdy, marmed && (q.size() < NS || out_rdy), q.size(), out_rdy);
         end
         if (pv && !pr) begin
            checks++;
            if (out_vld !== 1'b1 || out_data !== pd) begin
               errors++; $display("FAIL hold: vld=%b data=%h want vld=1 data=%h", out_vld, out_data, pd);
            end
         end
         if (out_vld && out_rdy) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL extra_word: got %h with nothing in flight", out_data);
            end else if (out_data !== q[0]) begin
               errors++; $display("FAIL out_data: got %h want %h", out_data, q[0]);
               void'(q.pop_front());
            end else void'(q.pop_front());
         end
         edone = 0; eerr = 0;
         if (in_vld && in_rdy) q.push_back(in_data ^ mask(mkey));
         if (key_start) begin
            mbusy = 1; mcnt = 0; msh = '0;
         end else if (mbusy && key_sin_vld) begin
            if (mcnt < KW) begin
               msh[mcnt] = key_sin; mcnt++;
`ifndef KEY_PARITY_EN
               if (mcnt == KW) commit();
`endif
            end else if ((^msh ^ key_sin) == 1'b0) commit();
            else begin
               eerr = 1; mbusy = 0; msh = '0;
            end
         end
         pv = out_vld; pr = out_rdy; pd = out_data;
      end
   end
   task automatic step();
      @(posedge clk); #1;
   endtask
   task automatic load_key(input logic [KW-1:0] k, input int gap, input bit badpar);
      key_start = 1; step(); key_start = 0;
      for (int i = 0; i < KW; i++) begin
         key_sin_vld = 0;
         repeat (gap) step();
         key_sin = k[i]; key_sin_vld = 1; step();
      end
`ifdef KEY_PARITY_EN
      key_sin = ^k ^ badpar; key_sin_vld = 1; step();
`endif
      key_sin_vld = 0; step();
   endtask
   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         in_vld = 1'($urandom_range(0, 1)); in_data = $urandom; out_rdy = 1'($urandom_range(0, 3) != 0); step();
      end
      in_vld = 0; out_rdy = 1; step(); step(); step();
   endtask
   task automatic test_reset();
      rst_n = 0; step(); step();
      checks++;
      if (key_armed !== 0 || key_busy !== 0 || out_vld !== 0 || in_rdy !== 0) begin
         errors++; $display("FAIL test_reset: armed=%b busy=%b out_vld=%b in_rdy=%b want 0", key_armed, key_busy, out_vld, in_rdy);
      end
      rst_n = 1; step();
   endtask
   task automatic test_prearm();
      in_vld = 1;
      for (int i = 0; i < 4; i++) begin
         in_data = $urandom; step();
         checks++;
         if (in_rdy !== 0) begin errors++; $display("FAIL prearm_in_rdy: got %b want 0", in_rdy); end
      end
      in_vld = 0; step();
   endtask
   task automatic test_passthrough();
      logic [DW-1:0] w [8];
      load_key('0, 0, 0);
      out_rdy = 1;
      for (int i = 0; i < 10; i++) begin
         in_vld = (i < 8);
         if (i < 8) begin
            w[i] = $urandom; in_data = w[i];
            checks++;
            if (in_rdy !== 1) begin errors++; $display("FAIL pass_in_rdy: cycle %0d got %b want 1", i, in_rdy); end
         end
         step();
         checks++;
         if (out_vld !== (i >= 1 && i <= 8)) begin
            errors++; $display("FAIL pass_latency: cycle %0d out_vld=%b want %b", i, out_vld, (i >= 1 && i <= 8));
         end else if (out_vld && out_data !== w[i-1]) begin
            errors++; $display("FAIL pass_data: got %h want %h", out_data, w[i-1]);
         end
      end
      in_vld = 0; step();
   endtask
   task automatic test_wrong_key();
      logic [DW-1:0] w;
      load_key(32'h0000_0001, 0, 0);
      w = $urandom; in_data = w; in_vld = 1; step(); in_vld = 0; step();
      checks++;
      if (out_vld !== 1 || out_data !== (w ^ 32'h1)) begin
         errors++; $display("FAIL wrong_key: vld=%b data=%h want vld=1 data=%h", out_vld, out_data, w ^ 32'h1);
      end
      step();
      stream(20);
   endtask
   task automatic test_reload_gaps();
      logic [KW-1:0] k;
      k = $urandom;
      fork
         load_key(k, 5, 0);
         stream(KW * 6 + 6);
      join
      stream(20);
   endtask
   task automatic test_backpressure();
      logic [DW-1:0] held;
      load_key($urandom, 0, 0);
      out_rdy = 0; in_vld = 1;
      for (int i = 0; i < NS; i++) begin in_data = $urandom; step(); end
      held = out_data;
      for (int i = 0; i < 4; i++) begin
         in_data = $urandom; step();
         checks++;
         if (in_rdy !== 0 || out_vld !== 1 || out_data !== held) begin
            errors++; $display("FAIL backpressure: in_rdy=%b out_vld=%b data=%h want 0,1,%h", in_rdy, out_vld, out_data, held);
         end
      end
      in_vld = 0; out_rdy = 1; step(); step(); step();
      checks++;
      if (q.size() != 0 || out_vld !== 0) begin
         errors++; $display("FAIL bp_drain: %0d words undelivered, out_vld=%b want 0", q.size(), out_vld);
      end
   endtask
   task automatic test_restart();
      key_start = 1; step(); key_start = 0;
      for (int i = 0; i < 10; i++) begin key_sin = 1'($urandom); key_sin_vld = 1; step(); end
      key_sin_vld = 0;
      fork
         load_key($urandom, 1, 0);
         stream(KW * 2 + 4);
      join
      stream(15);
   endtask
   task automatic test_parity();
      logic [KW-1:0] old;
      old = mkey;
      load_key($urandom, 0, 1);
      checks++;
      if (key_armed !== 1 || mkey !== old) begin
         errors++; $display("FAIL parity_reject: armed=%b, want 1 with old key kept", key_armed);
      end
      stream(10);
      load_key($urandom, 0, 0);
      stream(10);
   endtask
   task automatic test_midstream_reset();
      out_rdy = 0; in_vld = 1;
      for (int i = 0; i < 2; i++) begin in_data = $urandom; step(); end
      rst_n = 0; #1;
      checks++;
      if (key_armed !== 0 || out_vld !== 0) begin
         errors++; $display("FAIL midstream_reset: armed=%b out_vld=%b want 0,0", key_armed, out_vld);
      end
      step(); rst_n = 1; out_rdy = 1; step(); step();
      checks++;
      if (in_rdy !== 0 || out_vld !== 0) begin
         errors++; $display("FAIL post_reset: in_rdy=%b out_vld=%b want 0,0", in_rdy, out_vld);
      end
      in_vld = 0; step();
   endtask
   initial begin
      test_reset();
      test_prearm();
      test_passthrough();
      test_wrong_key();
      test_reload_gaps();
      test_backpressure();
      test_restart();
`ifdef KEY_PARITY_EN
      test_parity();
`endif
      test_midstream_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
